// File: rtl/hb_pkg.sv
// Constants shared by the half-band decimator and interpolators: data and
// coefficient widths, the non-zero half-band taps (1s17) and output clip limits.
package hb_pkg;

    localparam int DW        = 18;
    localparam int CW        = 18;
    localparam int AW        = 38;
    localparam int FRAC_BITS = 17;
    localparam int NTAPS     = 11;

    // Symmetric taps; odd taps other than the centre are zero and never computed
    localparam logic signed [CW-1:0] HB_H0 = 18'sd1534;
    localparam logic signed [CW-1:0] HB_H2 = -18'sd8454;
    localparam logic signed [CW-1:0] HB_H4 = 18'sd39688;
    localparam logic signed [CW-1:0] HB_H5 = 18'sd65536;

    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131072;

endpackage

// File: rtl/hb_sat_round.sv
// Accumulator-to-sample conversion: arithmetic right shift (floor) followed by
// clipping to the signed output range.
module hb_sat_round
    import hb_pkg::*;
#(
    parameter int IW    = AW,
    parameter int OW    = DW,
    parameter int SHIFT = FRAC_BITS
) (
    input  logic signed [IW-1:0] acc,
    output logic signed [OW-1:0] q
);

    localparam logic signed [IW-1:0] MAX_W = IW'(SAT_MAX);
    localparam logic signed [IW-1:0] MIN_W = IW'(SAT_MIN);

    logic signed [IW-1:0] shifted_s;

    assign shifted_s = acc >>> SHIFT;

    // Clip the shifted accumulator into the output range
    always_comb begin
        q = shifted_s[OW-1:0];
        if (shifted_s > MAX_W) begin
            q = OW'(SAT_MAX);
        end else if (shifted_s < MIN_W) begin
            q = OW'(SAT_MIN);
        end else begin
            q = shifted_s[OW-1:0];
        end
    end

endmodule

// File: rtl/half_band_decimator.sv
// 2:1 half-band decimator: 11-tap delay line, output-side polyphase compute on
// every second accepted sample, two pipeline stages to a registered y/y_valid.
module half_band_decimator
    import hb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic [DW-1:0] x_in,
    output logic [DW-1:0] y,
    output logic          y_valid
);

    logic signed [DW-1:0] x_r [0:NTAPS-1];
    logic                 phase_r;
    logic                 compute_r;
    logic                 prod_valid_r;
    logic signed [AW-1:0] p0_r, p2_r, p4_r, p5_r;
    logic signed [DW:0]   pre0_s, pre2_s, pre4_s;
    logic signed [AW-1:0] m0_s, m2_s, m4_s, m5_s;
    logic signed [AW-1:0] acc_s;
    logic signed [DW-1:0] y_sat_s;
    logic signed [DW-1:0] y_r;
    logic                 y_valid_r;

    // Pre-adds exploit coefficient symmetry; 19 bits hold the sum of two samples
    assign pre0_s = (DW+1)'(x_r[0]) + (DW+1)'(x_r[10]);
    assign pre2_s = (DW+1)'(x_r[2]) + (DW+1)'(x_r[8]);
    assign pre4_s = (DW+1)'(x_r[4]) + (DW+1)'(x_r[6]);

    assign m0_s  = AW'(pre0_s) * AW'(HB_H0);
    assign m2_s  = AW'(pre2_s) * AW'(HB_H2);
    assign m4_s  = AW'(pre4_s) * AW'(HB_H4);
    assign m5_s  = AW'(x_r[5]) * AW'(HB_H5);
    assign acc_s = p0_r + p2_r + p4_r + p5_r;

    hb_sat_round u_sat (
        .acc (acc_s),
        .q   (y_sat_s)
    );

    // Delay line and decimation phase advance on every accepted sample
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_r[k] <= '0;
            end
            phase_r <= 1'b0;
        end else if (clk_en) begin
            x_r[0] <= x_in;
            for (int k = 1; k < NTAPS; k++) begin
                x_r[k] <= x_r[k-1];
            end
            phase_r <= ~phase_r;
        end
    end

    // Stage 1: products taken from the line as it stood after the compute sample
    always_ff @(posedge clk) begin
        if (reset) begin
            compute_r    <= 1'b0;
            prod_valid_r <= 1'b0;
            p0_r         <= '0;
            p2_r         <= '0;
            p4_r         <= '0;
            p5_r         <= '0;
        end else begin
            compute_r    <= clk_en & phase_r;
            prod_valid_r <= compute_r;
            if (compute_r) begin
                p0_r <= m0_s;
                p2_r <= m2_s;
                p4_r <= m4_s;
                p5_r <= m5_s;
            end
        end
    end

    // Stage 2: accumulate, scale, clip and present the result
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= prod_valid_r;
            if (prod_valid_r) begin
                y_r <= y_sat_s;
            end
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;

endmodule
